// File: rtl/iir_sos_sched_pkg.sv
// Shared types and constants for the SOS cascade sequencer.
package iir_pkg;

    // Number of MAC taps per section (b0, b1, b2, a1, a2; a0 is normalised).
    localparam int NTAP = 5;

    typedef enum logic [2:0] {
        TAP_B0 = 3'd0,
        TAP_B1 = 3'd1,
        TAP_B2 = 3'd2,
        TAP_A1 = 3'd3,
        TAP_A2 = 3'd4
    } tap_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        WB    = 2'd3
    } state_t;

    // Cycles spent on one section: 5 issue cycles, MAC_LAT drain, 1 writeback.
    function automatic int sect_period(int mac_lat);
        return 6 + mac_lat;
    endfunction

endpackage

// File: rtl/iir_sos_sched_if.sv
// Control bundle between the sequencer and the shared MAC datapath.
interface iir_sos_sched_if #(
    parameter int SW = 2
);
    import iir_pkg::*;

    // dv_in is a single-cycle sample strobe with no ready: it is accepted only
    // when busy is low (IDLE or the final writeback cycle); a strobe seen while
    // busy is high is dropped and recorded in the sticky overrun flag.
    logic          dv_in;
    logic          overrun_clr;
    logic          busy;
    logic [SW-1:0] sect;
    logic [2:0]    tap;
    logic          mac_en;
    logic          acc_clr;
    logic          sect_done;
    logic          hist_shift;
    logic          dv_out;
    logic          overrun;
    state_t        dbg_state;

    modport master (
        output dv_in, overrun_clr,
        input  busy, sect, tap, mac_en, acc_clr, sect_done, hist_shift,
               dv_out, overrun, dbg_state
    );

    modport slave (
        input  dv_in, overrun_clr,
        output busy, sect, tap, mac_en, acc_clr, sect_done, hist_shift,
               dv_out, overrun, dbg_state
    );

endinterface

// File: rtl/iir_sos_sched.sv
// Schedules five MACs per section across NSECT cascaded biquads sharing one
// MAC datapath. All outputs are registered from the next-state decode.
module iir_sos_sched #(
    parameter int NSECT   = 4,
    parameter int MAC_LAT = 2
) (
    input logic              clk,
    input logic              rst,
    iir_sos_sched_if.slave   bus
);
    import iir_pkg::*;

    localparam int SW = (NSECT > 1) ? $clog2(NSECT) : 1;
    localparam logic [SW-1:0] SECT_LAST  = SW'(NSECT - 1);
    localparam logic [2:0]    DRAIN_LAST = (MAC_LAT > 0) ? 3'(MAC_LAT - 1) : 3'd0;
    localparam tap_t          TAP_LAST   = tap_t'(3'(NTAP - 1));

    state_t        state_q, state_n;
    logic [SW-1:0] sect_q, sect_n;
    tap_t          tap_q, tap_n;
    logic [2:0]    drain_q, drain_n;
    logic          mac_en_q, acc_clr_q, sect_done_q, dv_out_q, busy_q, overrun_q;

    // Next-state decode for the FSM and its tap/drain/section counters.
    always_comb begin
        state_n = state_q;
        sect_n  = sect_q;
        tap_n   = tap_q;
        drain_n = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.dv_in) begin
                    state_n = ISSUE;
                    sect_n  = '0;
                    tap_n   = TAP_B0;
                end
            end
            ISSUE: begin
                if (tap_q == TAP_LAST) begin
                    drain_n = '0;
                    state_n = (MAC_LAT == 0) ? WB : DRAIN;
                end else begin
                    tap_n = tap_t'(tap_q + 3'd1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_n = WB;
                end else begin
                    drain_n = drain_q + 3'd1;
                end
            end
            WB: begin
                if (sect_q != SECT_LAST) begin
                    sect_n  = sect_q + SW'(1);
                    tap_n   = TAP_B0;
                    state_n = ISSUE;
                end else if (bus.dv_in) begin
                    // Final writeback frees the datapath, so a new sample
                    // can start section 0 straight away.
                    sect_n  = '0;
                    tap_n   = TAP_B0;
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and registered strobes; overrun set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sect_q      <= '0;
            tap_q       <= TAP_B0;
            drain_q     <= '0;
            mac_en_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            sect_done_q <= 1'b0;
            dv_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            sect_q      <= sect_n;
            tap_q       <= tap_n;
            drain_q     <= drain_n;
            mac_en_q    <= (state_n == ISSUE);
            acc_clr_q   <= (state_n == ISSUE) && (tap_n == TAP_B0);
            sect_done_q <= (state_n == WB);
            dv_out_q    <= (state_n == WB) && (sect_n == SECT_LAST);
            busy_q      <= (state_n == ISSUE) || (state_n == DRAIN) ||
                           ((state_n == WB) && (sect_n != SECT_LAST));
            if (bus.dv_in && busy_q) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.sect       = sect_q;
    assign bus.tap        = tap_q;
    assign bus.mac_en     = mac_en_q;
    assign bus.acc_clr    = acc_clr_q;
    assign bus.sect_done  = sect_done_q;
    assign bus.hist_shift = sect_done_q;
    assign bus.dv_out     = dv_out_q;
    assign bus.overrun    = overrun_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/iir_sos_sched.md
Name: iir_sos_sched

Overview:
Sequencer for a cascade of NSECT second-order IIR sections that share one multiply-accumulate datapath (iir_mac, outside this block). Each sample needs five MACs per section (b0,b1,b2,a1,a2; a0 is normalised to 1 and never multiplied). Sections run in order, because each section's output is the next section's input. The block issues tap/section selects and accumulator strobes, and flags samples that arrive while it is busy. It is control only and carries no data.

Parameters:
NSECT, 4, number of cascaded SOS sections (1..16)
MAC_LAT, 2, cycles from mac_en to a valid accumulator result (0..7)
SW, $clog2(NSECT) (min 1), derived width of sect

Ports:
clk  in  1  system clock
rst  in  1  reset
dv_in  in  1  new input sample present at the cascade input
overrun_clr  in  1  clears the sticky overrun flag
busy  out  1  schedule in progress; dv_in will be dropped
sect  out  SW  section currently served (coefficient/history bank select)
tap  out  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
mac_en  out  1  MAC operands valid this cycle
acc_clr  out  1  accumulator loads the product instead of adding it
sect_done  out  1  accumulator holds y[n] of section sect
hist_shift  out  1  shift the x/y history of section sect
dv_out  out  1  final-section output valid
overrun  out  1  sticky: a sample was dropped

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high.
- All outputs are registered.
- Reset values: state IDLE, sect=0, tap=0, all strobes 0, busy=0, overrun=0.
- FSM states:
  - IDLE: busy=0. dv_in moves to ISSUE with sect=0, tap=0.
  - ISSUE: mac_en=1 and acc_clr=(tap==0). tap increments 0..4. After tap==4 go to DRAIN, or to WB if MAC_LAT==0.
  - DRAIN: lasts MAC_LAT cycles, counted by a drain counter. All strobes are 0, tap holds at 4.
  - WB: lasts one cycle. sect_done=1 and hist_shift=1.
    - If sect<NSECT-1: sect++, tap=0, go to ISSUE.
    - If sect==NSECT-1: dv_out=1, busy=0. dv_in in this cycle is accepted and goes to ISSUE with sect=0. Otherwise go to IDLE.
- busy=1 in ISSUE, DRAIN and every WB except the final one.
- Timing, with dv_in accepted at cycle T:
  - Section k (0-based) issues taps at cycles T+1+k*P .. T+5+k*P, where P=6+MAC_LAT.
  - sect_done for section k is at T+(k+1)*P.
  - dv_out is at T+NSECT*P.
  - Minimum accepted dv_in spacing is NSECT*P.
- In IDLE, sect and tap hold their last values; mac_en=0.
- dv_in while busy=1:
  - The sample is ignored and the schedule is unaffected.
  - overrun=1 from the next cycle.
  - If overrun_clr is asserted in the same cycle, set wins.
- overrun_clr alone clears overrun on the next cycle.
- rst mid-operation: the next cycle is IDLE with reset values. No dv_out is produced for the aborted sample. Datapath history is not cleared by this block.

Decomposition:
- Package iir_pkg holds:
  - NTAP=5
  - typedef enum tap_t {TAP_B0, TAP_B1, TAP_B2, TAP_A1, TAP_A2}
  - typedef enum state_t {IDLE, ISSUE, DRAIN, WB}
  - function sect_period(MAC_LAT) = 6+MAC_LAT
- No sub-module: one FSM plus tap, drain and section counters in a single module.

Test Plan:
- Reset: hold rst 3 cycles with dv_in toggling -> all outputs 0 during and after reset, until the first dv_in after release.
- Single sample (NSECT=4, MAC_LAT=2), dv_in at cycle 0 ->
  - mac_en at cycles 1-5 with tap 0..4 and sect=0; acc_clr only at cycle 1.
  - sect_done/hist_shift at 8, 16, 24, 32 with sect 0..3.
  - dv_out only at 32; busy=1 from 1 to 31, busy=0 at 32.
- Back-to-back: dv_in at 0 and 32 -> second sample accepted; sect=0, tap=0, acc_clr at 33; dv_out at 32 and 64; overrun stays 0.
- Overrun: dv_in at 0 and 10 -> second dropped; overrun=1 from 11; dv_out still only at 32. overrun_clr at 40 -> overrun=0 at 41.
- Overrun priority: dv_in at 0, then dv_in and overrun_clr together at 5 -> overrun=1 at 6.
- Reset mid-op: dv_in at 0, rst at 12 -> IDLE at 13, no dv_out at 32. dv_in at 20 -> dv_out at 52.
- MAC_LAT=0: dv_in at 0 -> sect_done at 6, 12, 18, 24; dv_out at 24; no DRAIN cycles.
